// File: rtl/dma_ctrl_mc.sv
`default_nettype none
// ============================================================================
// dma_ctrl_mc : multi-channel DMA engine, round-robin word-interleaved copy
// Rev 1.0
// ============================================================================
module dma_ctrl_mc #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              start,
  input  logic [N_CH-1:0]   irq_clr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   irq,
  output logic              cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_LAT, S_WR} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     cur_q, cur_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   src_q [N_CH];
  logic [ADDR_W-1:0]   src_d [N_CH];
  logic [ADDR_W-1:0]   dst_q [N_CH];
  logic [ADDR_W-1:0]   dst_d [N_CH];
  logic [LEN_W-1:0]    len_q [N_CH];
  logic [LEN_W-1:0]    len_d [N_CH];
  logic [N_CH-1:0]     busy_q, busy_d;
  logic [N_CH-1:0]     irq_q, irq_d, irq_set;
  logic                cfg_err_q, cfg_err_d;
  logic                ch_ok;
  logic [CH_W-1:0]     grant;

  // Lowest requesting index strictly above ptr, wrapping; ptr itself is checked last.
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                              input logic [CH_W-1:0] ptr);
    logic [CH_W-1:0] pick;
    pick = ptr;
    for (int k = N_CH; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N_CH]) pick = CH_W'((int'(ptr) + k) % N_CH);
    end
    return pick;
  endfunction

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rr_d      = rr_q;
    data_d    = data_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    busy_d    = busy_q;
    irq_set   = '0;
    cfg_err_d = 1'b0;
    grant     = rr_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ch_ok     = int'(cfg_ch) < N_CH;

    if ((cfg_wr || start) && (!ch_ok || busy_q[cfg_ch])) begin
      cfg_err_d = 1'b1;
    end else begin
      if (cfg_wr) begin
        src_d[cfg_ch] = cfg_src;
        dst_d[cfg_ch] = cfg_dst;
        len_d[cfg_ch] = cfg_len;
      end
      // start sees the length just loaded by a simultaneous cfg_wr
      if (start) begin
        if (len_d[cfg_ch] != '0) busy_d[cfg_ch]  = 1'b1;
        else                     irq_set[cfg_ch] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|busy_q) begin
          grant   = rr_pick(busy_q, rr_q);
          cur_d   = grant;
          rr_d    = grant;
          state_d = S_RD;
        end
      end
      S_RD: begin
        mem_en   = 1'b1;
        mem_addr = src_q[cur_q];
        state_d  = S_LAT;
      end
      S_LAT: begin
        data_d  = mem_rdata;
        state_d = S_WR;
      end
      S_WR: begin
        mem_en        = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = dst_q[cur_q];
        mem_wdata     = data_q;
        src_d[cur_q]  = src_q[cur_q] + ADDR_W'(1);
        dst_d[cur_q]  = dst_q[cur_q] + ADDR_W'(1);
        if (len_q[cur_q] != '0) len_d[cur_q] = len_q[cur_q] - LEN_W'(1);
        if (len_q[cur_q] <= LEN_W'(1)) begin
          busy_d[cur_q]  = 1'b0;
          irq_set[cur_q] = 1'b1;
        end
        // busy_d already includes channels started this cycle
        if (|busy_d) begin
          grant   = rr_pick(busy_d, rr_q);
          cur_d   = grant;
          rr_d    = grant;
          state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    irq_d = (irq_q & ~irq_clr) | irq_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      rr_q      <= CH_W'(N_CH - 1);
      data_q    <= '0;
      busy_q    <= '0;
      irq_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        len_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      rr_q      <= rr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      irq_q     <= irq_d;
      cfg_err_q <= cfg_err_d;
      for (int i = 0; i < N_CH; i++) begin
        src_q[i] <= src_d[i];
        dst_q[i] <= dst_d[i];
        len_q[i] <= len_d[i];
      end
    end
  end

  assign busy    = busy_q;
  assign irq     = irq_q;
  assign cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_ctrl_mc.sv
`default_nettype none
// ============================================================================
// tb_dma_ctrl_mc : scoreboard bench for dma_ctrl_mc with a word-copy memory model
// Rev 1.0
// ============================================================================
module tb_dma_ctrl_mc;
  localparam int N_CH = 2, ADDR_W = 8, DATA_W = 8, LEN_W = 8, CH_W = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [ADDR_W-1:0] cfg_src = '0;
  logic [ADDR_W-1:0] cfg_dst = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              start = 1'b0;
  logic [N_CH-1:0]   irq_clr = '0;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [N_CH-1:0]   busy, irq;
  logic              cfg_err;

  dma_ctrl_mc #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_len(cfg_len), .start(start), .irq_clr(irq_clr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .irq(irq), .cfg_err(cfg_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory attached to the DUT, plus a reference image updated by the copy model
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       fill_req = 1'b0;
  always @(posedge clk) begin
    if (fill_req) for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  int passed = 0, total = 0;
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];
  int rd_cyc [$], rd_adr [$], wr_cyc [$], wr_adr [$];
  logic [15:0] e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: log every access, pop the matching channel's expected write
  always @(negedge clk) begin
    if (rst && mem_en) begin
      if (mem_we) begin
        wr_cyc.push_back(cyc);
        wr_adr.push_back(int'(mem_addr));
        if (exp0.size() > 0 && exp0[0][15:8] == mem_addr) begin
          e = exp0.pop_front();
          chk("wr_data_ch0", 32'(mem_wdata), 32'(e[7:0]));
        end else if (exp1.size() > 0 && exp1[0][15:8] == mem_addr) begin
          e = exp1.pop_front();
          chk("wr_data_ch1", 32'(mem_wdata), 32'(e[7:0]));
        end else begin
          total++;
          $display("FAIL unexpected_write: addr %0h data %0h (cycle %0d)", mem_addr, mem_wdata, cyc);
        end
      end else begin
        rd_cyc.push_back(cyc);
        rd_adr.push_back(int'(mem_addr));
      end
    end
  end

  // Reference: word-by-word sequential copy, modulo-256 addressing
  task automatic model_push(input int ch, input int src, input int dst, input int len);
    for (int i = 0; i < len; i++) begin
      int s, d;
      s = (src + i) % 256;
      d = (dst + i) % 256;
      ref_mem[d] = ref_mem[s];
      if (ch == 0) exp0.push_back({8'(d), ref_mem[d]});
      else         exp1.push_back({8'(d), ref_mem[d]});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    rd_cyc.delete(); rd_adr.delete(); wr_cyc.delete(); wr_adr.delete();
  endtask

  task automatic load_mem();
    fill_req = 1'b1;
    tick(1);
    fill_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    exp0.delete(); exp1.delete(); clr_logs();
    load_mem();
    tick(1);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    rst = 1'b1;
    tick(1);
  endtask

  task automatic cfg_t(input int ch, input int src, input int dst, input int len, input bit go);
    cfg_wr = 1'b1; start = go; cfg_ch = CH_W'(ch);
    cfg_src = 8'(src); cfg_dst = 8'(dst); cfg_len = 8'(len);
    tick(1);
    cfg_wr = 1'b0; start = 1'b0;
  endtask

  task automatic start_t(input int ch, output int k);
    start = 1'b1; cfg_ch = CH_W'(ch); k = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== '0 && n < budget) begin
      tick(1);
      n++;
    end
    chk("idle_within_budget", 32'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k, l0, l1, s0, s1, d0, d1;
    logic [7:0] old_fe;

    // Single-channel copy with irq set/clear race on completion
    do_reset();
    ref_mem[8'h10] = 8'hA1; ref_mem[8'h11] = 8'hB2; ref_mem[8'h12] = 8'hC3;
    load_mem();
    cfg_t(0, 8'h10, 8'h40, 3, 1'b0);
    model_push(0, 8'h10, 8'h40, 3);
    clr_logs();
    start_t(0, k);
    chk("busy_after_start", 32'(busy), 1);
    tick(9);
    chk("busy_final_wr", 32'(busy), 1);
    irq_clr = 2'b01;
    tick(1);
    irq_clr = 2'b00;
    chk("done_cycle", 32'(cyc - k), 11);
    chk("busy_fall", 32'(busy), 0);
    chk("irq_set_wins", 32'(irq), 1);
    chk("rd_count", 32'(rd_cyc.size()), 3);
    chk("wr_count", 32'(wr_cyc.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk("rd_cycle", 32'(rd_cyc[i] - k), 32'(2 + 3 * i));
      chk("wr_cycle", 32'(wr_cyc[i] - k), 32'(4 + 3 * i));
    end
    chk("copy_mem40", 32'(mem[8'h40]), 32'h A1);
    chk("copy_mem41", 32'(mem[8'h41]), 32'h B2);
    chk("copy_mem42", 32'(mem[8'h42]), 32'h C3);
    tick(2);
    irq_clr = 2'b01;
    tick(1);
    irq_clr = 2'b00;
    chk("irq_cleared", 32'(irq), 0);

    // Two channels started on consecutive cycles interleave word by word
    do_reset();
    cfg_t(0, 8'h00, 8'h80, 2, 1'b0);
    cfg_t(1, 8'h20, 8'hA0, 2, 1'b0);
    model_push(0, 8'h00, 8'h80, 2);
    model_push(1, 8'h20, 8'hA0, 2);
    clr_logs();
    start_t(0, k);
    start_t(1, k);
    wait_idle(100);
    chk("ilv_wr_count", 32'(wr_adr.size()), 4);
    chk("ilv_order0", 32'(wr_adr[0]), 32'h80);
    chk("ilv_order1", 32'(wr_adr[1]), 32'hA0);
    chk("ilv_order2", 32'(wr_adr[2]), 32'h81);
    chk("ilv_order3", 32'(wr_adr[3]), 32'hA1);
    tick(1);
    chk("ilv_irqs", 32'(irq), 3);

    // Zero length start, then config/start against a busy channel
    do_reset();
    cfg_t(0, 8'h10, 8'h60, 0, 1'b0);
    start_t(0, k);
    chk("zero_irq", 32'(irq), 1);
    chk("zero_busy", 32'(busy), 0);
    tick(4);
    chk("zero_no_mem", 32'(rd_cyc.size() + wr_cyc.size()), 0);
    cfg_t(1, 8'h20, 8'h90, 4, 1'b1);
    model_push(1, 8'h20, 8'h90, 4);
    chk("cfgstart_busy", 32'(busy), 2);
    cfg_t(1, 8'h30, 8'h70, 2, 1'b0);
    chk("cfg_err_pulse", 32'(cfg_err), 1);
    tick(1);
    chk("cfg_err_width", 32'(cfg_err), 0);
    start_t(1, k);
    chk("start_busy_err", 32'(cfg_err), 1);
    wait_idle(100);
    tick(1);
    chk("busy_ch_irq", 32'(irq), 3);
    chk("busy_ch_drain", 32'(exp1.size()), 0);

    // Address wrap-around with overlapping src/dst
    do_reset();
    old_fe = ref_mem[8'hFE];
    cfg_t(0, 8'hFE, 8'hFF, 3, 1'b0);
    model_push(0, 8'hFE, 8'hFF, 3);
    clr_logs();
    start_t(0, k);
    wait_idle(100);
    chk("wrap_rd0", 32'(rd_adr[0]), 32'hFE);
    chk("wrap_rd1", 32'(rd_adr[1]), 32'hFF);
    chk("wrap_rd2", 32'(rd_adr[2]), 32'h00);
    chk("wrap_wr0", 32'(wr_adr[0]), 32'hFF);
    chk("wrap_wr1", 32'(wr_adr[1]), 32'h00);
    chk("wrap_wr2", 32'(wr_adr[2]), 32'h01);
    chk("wrap_mem01", 32'(mem[8'h01]), 32'(old_fe));

    // Reset during LAT of word 2 of 4
    do_reset();
    cfg_t(0, 8'h10, 8'h50, 4, 1'b0);
    model_push(0, 8'h10, 8'h50, 4);
    clr_logs();
    start_t(0, k);
    tick(5);
    chk("pre_rst_writes", 32'(wr_cyc.size()), 1);
    rst = 1'b0;
    #1;
    chk("abort_mem_en", 32'(mem_en), 0);
    chk("abort_mem_addr", 32'(mem_addr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_irq", 32'(irq), 0);
    exp0.delete();
    clr_logs();
    tick(2);
    rst = 1'b1;
    tick(10);
    chk("post_rst_quiet", 32'(rd_cyc.size() + wr_cyc.size()), 0);

    // Randomised dual-channel transfers over disjoint regions
    do_reset();
    for (int it = 0; it < 8; it++) begin
      l0 = $urandom_range(1, 8);  l1 = $urandom_range(1, 8);
      s0 = $urandom_range(8'h00, 8'h37); d0 = $urandom_range(8'h80, 8'hB7);
      s1 = $urandom_range(8'h40, 8'h77); d1 = $urandom_range(8'hC0, 8'hF7);
      cfg_t(0, s0, d0, l0, 1'b0);
      model_push(0, s0, d0, l0);
      model_push(1, s1, d1, l1);
      if (it % 2 == 1) begin
        cfg_t(1, s1, d1, l1, 1'b1);
        tick($urandom_range(0, 4));
        start_t(0, k);
      end else begin
        cfg_t(1, s1, d1, l1, 1'b0);
        start_t(0, k);
        tick($urandom_range(0, 5));
        start_t(1, k);
      end
      wait_idle(300);
      tick(1);
      chk("rnd_irqs", 32'(irq), 3);
      chk("rnd_drain", 32'(exp0.size() + exp1.size()), 0);
      irq_clr = 2'b11;
      tick(1);
      irq_clr = 2'b00;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
